// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared binary/Gray conversion helpers, sized for the widest counter.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_CNT_MAX_WIDTH = 32;

  function automatic logic [GRAY_CNT_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_CNT_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Narrower callers zero-extend; the leading zeros leave the low bits exact.
  function automatic logic [GRAY_CNT_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_CNT_MAX_WIDTH-1:0] g
  );
    logic [GRAY_CNT_MAX_WIDTH-1:0] b;
    b[GRAY_CNT_MAX_WIDTH-1] = g[GRAY_CNT_MAX_WIDTH-1];
    for (int i = GRAY_CNT_MAX_WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : gray_updown_counter
// Purpose  : Up/down binary counter with registered Gray output, load and wrap
//            pulse. Define GRAY_CNT_SAT_EN to saturate at the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_tc;
  logic             w_wrap_next;

  always_comb begin
    w_tc        = up ? (r_bin == c_max) : (r_bin == '0);
    w_step      = up ? (r_bin + c_one) : (r_bin - c_one);
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_bin;
    end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!w_tc) begin
        w_bin_next = w_step;
      end
`else
      w_bin_next  = w_step;
      w_wrap_next = w_tc;
`endif
    end
    // Gray is derived from the next binary so both registers update together.
    w_gray_next = WIDTH'(bin2gray(GRAY_CNT_MAX_WIDTH'(w_bin_next)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign wrap = r_wrap;
  assign tc   = w_tc;

endmodule
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_updown_counter
// Purpose  : Directed WIDTH=4 vectors plus a WIDTH=8 random soak against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_updown_counter;

`ifdef GRAY_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
  logic [3:0] lb4 = '0;
  logic [3:0] bin4, gray4;
  logic       tc4, wrap4;
  logic       en8 = 1'b0, up8 = 1'b0, load8 = 1'b0;
  logic [7:0] lb8 = '0;
  logic [7:0] bin8, gray8;
  logic       tc8, wrap8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic [7:0] m_bin, nb, m_gray, ng;
  logic       nw, etc8;
  logic [3:0] eb;

  gray_updown_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .load(load4), .load_bin(lb4),
    .bin(bin4), .gray(gray4), .tc(tc4), .wrap(wrap4)
  );

  gray_updown_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(load8), .load_bin(lb8),
    .bin(bin8), .gray(gray8), .tc(tc8), .wrap(wrap8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step4(input logic e, input logic u, input logic l, input logic [3:0] lb);
    en4 = e; up4 = u; load4 = l; lb4 = lb;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_bin", bin4, 4'h0);
    check_eq("rst_gray", gray4, 4'h0);
    check_eq("rst_wrap", wrap4, 1'b0);

    // Count up through a full cycle.
    @(negedge clk);
    rst_n = 1'b1; en4 = 1'b1; up4 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      eb = (k == 16 && SAT) ? 4'hF : 4'(k % 16);
      check_eq("up_bin", bin4, eb);
      check_eq("up_gray", gray4, gtab[eb]);
      check_eq("up_wrap", wrap4, (k == 16 && !SAT));
      check_eq("up_tc", tc4, (eb == 4'hF));
    end
    step4(1'b0, 1'b1, 1'b0, 4'h0);
    check_eq("wrap_clear", wrap4, 1'b0);
    check_eq("idle_bin", bin4, SAT ? 4'hF : 4'h0);

    // Count down from reset.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1; en4 = 1'b1; up4 = 1'b0;
    #1;
    check_eq("dn_tc0", tc4, 1'b1);
    @(posedge clk); #1;
    check_eq("dn_bin", bin4, SAT ? 4'h0 : 4'hF);
    check_eq("dn_gray", gray4, SAT ? 4'h0 : 4'h8);
    check_eq("dn_wrap", wrap4, !SAT);
    @(posedge clk); #1;
    check_eq("dn2_bin", bin4, SAT ? 4'h0 : 4'hE);
    check_eq("dn2_gray", gray4, SAT ? 4'h0 : 4'h9);
    check_eq("dn2_wrap", wrap4, 1'b0);

    // Load has priority, never wraps.
    step4(1'b1, 1'b1, 1'b1, 4'b1010);
    check_eq("ld_bin", bin4, 4'hA);
    check_eq("ld_gray", gray4, 4'hF);
    check_eq("ld_wrap", wrap4, 1'b0);
    step4(1'b1, 1'b1, 1'b1, 4'hF);
    check_eq("ld15_gray", gray4, 4'h8);
    check_eq("ld15_tc", tc4, 1'b1);
    step4(1'b1, 1'b1, 1'b1, 4'h3);
    check_eq("ldtc_bin", bin4, 4'h3);
    check_eq("ldtc_gray", gray4, 4'h2);
    check_eq("ldtc_wrap", wrap4, 1'b0);
    step4(1'b0, 1'b0, 1'b0, 4'h0);
    check_eq("hold_bin", bin4, 4'h3);
    check_eq("hold_gray", gray4, 4'h2);
    step4(1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("dir_up", gray4, 4'h6);
    step4(1'b1, 1'b0, 1'b0, 4'h0);
    check_eq("dir_dn_bin", bin4, 4'h3);
    check_eq("dir_dn_gray", gray4, 4'h2);

    // Reset mid-count, observed before the next clock edge.
    step4(1'b1, 1'b1, 1'b1, 4'h7);
    check_eq("pre_rst_bin", bin4, 4'h7);
    en4 = 1'b0; load4 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_bin", bin4, 4'h0);
    check_eq("arst_gray", gray4, 4'h0);
    check_eq("arst_wrap", wrap4, 1'b0);
    #2 rst_n = 1'b1;
    en4 = 1'b1; up4 = 1'b1;
    @(posedge clk); #1;
    check_eq("resume_bin", bin4, 4'h1);
    check_eq("resume_gray", gray4, 4'h1);
    en4 = 1'b0;

    // WIDTH=8 random soak against the bench model.
    m_bin = 8'h0;
    m_gray = 8'h0;
    for (int i = 0; i < 10000; i++) begin
      en8   = ($urandom_range(0, 3) != 0);
      up8   = 1'($urandom_range(0, 1));
      load8 = ($urandom_range(0, 15) == 0);
      lb8   = 8'($urandom);
      #1;
      etc8 = up8 ? (m_bin == 8'hFF) : (m_bin == 8'h00);
      check_eq("r_tc", tc8, etc8);
      nw = 1'b0;
      if (load8) begin
        nb = lb8;
      end else if (en8) begin
        if (SAT && etc8) begin
          nb = m_bin;
        end else begin
          nb = up8 ? m_bin + 8'd1 : m_bin - 8'd1;
          nw = etc8;
        end
      end else begin
        nb = m_bin;
      end
      ng = nb ^ (nb >> 1);
      @(posedge clk); #1;
      check_eq("r_bin", bin8, nb);
      check_eq("r_gray", gray8, ng);
      check_eq("r_wrap", wrap8, nw);
      check_eq("r_g2b", g2b8(gray8), nb);
      if (!load8 && nb != m_bin) check_eq("r_onebit", $countones(gray8 ^ m_gray), 1);
      m_bin = nb;
      m_gray = ng;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
